// File: rtl/phys_reg_free_list.sv
// Physical register free list: circular FIFO of free IDs with a start-up fill sequencer,
// speculative allocation head, committed head, and flush recovery to the committed state.
module phys_reg_free_list #(
  parameter int unsigned NUM_PHYREG  = 128,
  parameter int unsigned NUM_ARCHREG = 32,
  localparam int unsigned DEPTH      = NUM_PHYREG - NUM_ARCHREG,
  localparam int unsigned IdW        = $clog2(NUM_PHYREG),
  localparam int unsigned PtrW       = $clog2(DEPTH),
  localparam int unsigned CntW       = $clog2(DEPTH + 1)
) (
  input  logic            SIG_CLK,
  input  logic            SIG_RSTn,
  input  logic            allocReq,
  output logic            allocReady,
  output logic            allocGnt,
  output logic [IdW-1:0]  allocId,
  input  logic            commitValid,
  input  logic            commitHasDst,
  input  logic [IdW-1:0]  commitPrevId,
  input  logic            flushReq,
  output logic [CntW-1:0] freeCount,
  output logic            initDone,
  output logic            overflowErr
);

  typedef enum logic [1:0] {StInit, StReady, StRecover} state_e;

  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  state_e            state_q, state_d;
  logic [PtrW-1:0]   spec_head_q, spec_head_d;
  logic [PtrW-1:0]   commit_head_q, commit_head_d;
  logic [PtrW-1:0]   tail_q, tail_d;
  logic [PtrW-1:0]   init_ptr_q, init_ptr_d;
  logic [CntW-1:0]   free_count_q, free_count_d;
  logic [CntW-1:0]   inflight_q, inflight_d;
  logic              overflow_err_q, overflow_err_d;
  logic [IdW-1:0]    mem_q [DEPTH];

  logic              mem_we;
  logic [PtrW-1:0]   mem_waddr;
  logic [IdW-1:0]    mem_wdata;
  logic              commit_fire;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign commit_fire = commitValid && commitHasDst;

  assign allocReady  = (state_q == StReady) && (free_count_q != '0);
  assign allocGnt    = allocReq && allocReady && !flushReq;
  assign allocId     = allocGnt ? mem_q[spec_head_q] : '0;
  assign freeCount   = free_count_q;
  assign initDone    = (state_q != StInit);
  assign overflowErr = overflow_err_q;

  always_comb begin
    state_d        = state_q;
    spec_head_d    = spec_head_q;
    commit_head_d  = commit_head_q;
    tail_d         = tail_q;
    init_ptr_d     = init_ptr_q;
    free_count_d   = free_count_q;
    inflight_d     = inflight_q;
    overflow_err_d = overflow_err_q;
    mem_we         = 1'b0;
    mem_waddr      = tail_q;
    mem_wdata      = commitPrevId;

    unique case (state_q)
      StInit: begin
        mem_we       = 1'b1;
        mem_waddr    = init_ptr_q;
        mem_wdata    = IdW'(NUM_ARCHREG) + IdW'(init_ptr_q);
        init_ptr_d   = ptr_inc(init_ptr_q);
        tail_d       = ptr_inc(tail_q);
        free_count_d = free_count_q + CntOne;
        if (init_ptr_q == PtrW'(DEPTH - 1)) state_d = StReady;
        // Commits cannot be legal before the list exists; flag and drop.
        if (commitValid) overflow_err_d = 1'b1;
      end
      StReady, StRecover: begin
        if (allocGnt) begin
          spec_head_d  = ptr_inc(spec_head_q);
          free_count_d = free_count_q - CntOne;
          inflight_d   = inflight_q + CntOne;
        end
        if (commit_fire) begin
          if (free_count_q == CntFull && !allocGnt) begin
            overflow_err_d = 1'b1;
          end else begin
            mem_we        = 1'b1;
            tail_d        = ptr_inc(tail_q);
            free_count_d  = free_count_d + CntOne;
            commit_head_d = ptr_inc(commit_head_q);
            if (inflight_d != '0) inflight_d = inflight_d - CntOne;
          end
        end
        // Restore uses post-commit values so a same-cycle retire is not lost.
        if (flushReq) begin
          spec_head_d  = commit_head_d;
          free_count_d = free_count_d + inflight_d;
          inflight_d   = '0;
          state_d      = StRecover;
        end else if (state_q == StRecover) begin
          state_d = StReady;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge SIG_CLK or negedge SIG_RSTn) begin
    if (!SIG_RSTn) begin
      state_q        <= StInit;
      spec_head_q    <= '0;
      commit_head_q  <= '0;
      tail_q         <= '0;
      init_ptr_q     <= '0;
      free_count_q   <= '0;
      inflight_q     <= '0;
      overflow_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      spec_head_q    <= spec_head_d;
      commit_head_q  <= commit_head_d;
      tail_q         <= tail_d;
      init_ptr_q     <= init_ptr_d;
      free_count_q   <= free_count_d;
      inflight_q     <= inflight_d;
      overflow_err_q <= overflow_err_d;
    end
  end

  always_ff @(posedge SIG_CLK) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

endmodule
